// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared 640x480@60 VGA timing constants and grid area count
package vga_pkg;

    // Horizontal timing, in pixel ticks
    localparam logic [9:0] H_VISIBLE    = 10'd640;
    localparam logic [9:0] H_FRONT      = 10'd16;
    localparam logic [9:0] H_SYNC       = 10'd96;
    localparam logic [9:0] H_BACK       = 10'd48;
    localparam logic [9:0] H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam logic [9:0] H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC;

    // Vertical timing, in lines
    localparam logic [9:0] V_VISIBLE    = 10'd480;
    localparam logic [9:0] V_FRONT      = 10'd10;
    localparam logic [9:0] V_SYNC       = 10'd2;
    localparam logic [9:0] V_BACK       = 10'd33;
    localparam logic [9:0] V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam logic [9:0] V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC;

    // Board is 2 rows by 3 columns of square cells
    localparam int AREA_COUNT = 6;

endpackage

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - pixel tick, h/v counters and raw sync/video_on (VGA_CLKDIV_EN: tick every 4th clk)
module vga_timing
    import vga_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic       tick,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       hsync_raw,
    output logic       vsync_raw,
    output logic       video_on_raw
);

    logic [9:0] hcount_q, hcount_d;
    logic [9:0] vcount_q, vcount_d;

`ifdef VGA_CLKDIV_EN
    logic [1:0] div_q, div_d;

    // Free-running divider; the pixel tick is its terminal count
    always_comb begin
        div_d = div_q + 2'd1;
    end

    // Divider register, cleared so the first tick lands 4 clocks after reset
    always_ff @(posedge clk) begin
        if (rst) div_q <= 2'd0;
        else     div_q <= div_d;
    end

    assign tick = (div_q == 2'd3);
`else
    assign tick = 1'b1;
`endif

    // Raster position advance: column wraps into the next line, line wraps into the next frame
    always_comb begin
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (tick) begin
            if (hcount_q == H_TOTAL - 10'd1) begin
                hcount_d = 10'd0;
                vcount_d = (vcount_q == V_TOTAL - 10'd1) ? 10'd0 : vcount_q + 10'd1;
            end else begin
                hcount_d = hcount_q + 10'd1;
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_q <= 10'd0;
            vcount_q <= 10'd0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
        end
    end

    assign hcount       = hcount_q;
    assign vcount       = vcount_q;
    assign hsync_raw    = !((hcount_q >= H_SYNC_START) && (hcount_q < H_SYNC_END));
    assign vsync_raw    = !((vcount_q >= V_SYNC_START) && (vcount_q < V_SYNC_END));
    assign video_on_raw = (hcount_q < H_VISIBLE) && (vcount_q < V_VISIBLE);

endmodule

// File: rtl/vga_scan_area.sv
// rtl/vga_scan_area.sv - VGA scan with 3x2 cell decode and frame-stable board latch (option: VGA_CLKDIV_EN)
module vga_scan_area
    import vga_pkg::*;
#(
    parameter int H_ORG = 20,
    parameter int V_ORG = 40,
    parameter int CELL  = 200
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           encode_in,
    output logic [31:0]           encode_out,
    output logic [AREA_COUNT-1:0] area,
    output logic [9:0]            x,
    output logic [9:0]            y,
    output logic                  video_on,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  frame_start
);

    // Cell boundaries along each axis
    localparam logic [9:0] H_LO = 10'(H_ORG);
    localparam logic [9:0] H_C1 = 10'(H_ORG + CELL);
    localparam logic [9:0] H_C2 = 10'(H_ORG + 2 * CELL);
    localparam logic [9:0] H_HI = 10'(H_ORG + 3 * CELL);
    localparam logic [9:0] V_LO = 10'(V_ORG);
    localparam logic [9:0] V_R1 = 10'(V_ORG + CELL);
    localparam logic [9:0] V_HI = 10'(V_ORG + 2 * CELL);
    localparam logic [AREA_COUNT-1:0] AREA_ONE = AREA_COUNT'(1);

    logic       tick;
    logic [9:0] hcount, vcount;
    logic       hsync_raw, vsync_raw, video_on_raw;

    vga_timing u_timing (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .hcount       (hcount),
        .vcount       (vcount),
        .hsync_raw    (hsync_raw),
        .vsync_raw    (vsync_raw),
        .video_on_raw (video_on_raw)
    );

    logic       in_grid;
    logic       row_hi;
    logic [1:0] col_sel;
    logic [2:0] cell_idx;
    logic [9:0] x_base, y_base;

    // Cell decode by comparing against fixed boundaries instead of dividing
    always_comb begin
        in_grid = (hcount >= H_LO) && (hcount < H_HI) && (vcount >= V_LO) && (vcount < V_HI);
        if (hcount >= H_C2) begin
            col_sel = 2'd2;
            x_base  = H_C2;
        end else if (hcount >= H_C1) begin
            col_sel = 2'd1;
            x_base  = H_C1;
        end else begin
            col_sel = 2'd0;
            x_base  = H_LO;
        end
        if (vcount >= V_R1) begin
            row_hi = 1'b1;
            y_base = V_R1;
        end else begin
            row_hi = 1'b0;
            y_base = V_LO;
        end
        cell_idx = (row_hi ? 3'd3 : 3'd0) + {1'b0, col_sel};
    end

    logic [31:0]           encode_out_q, encode_out_d;
    logic [AREA_COUNT-1:0] area_q, area_d;
    logic [9:0]            x_q, x_d, y_q, y_d;
    logic                  video_on_q, video_on_d;
    logic                  hsync_q, hsync_d, vsync_q, vsync_d;
    logic                  frame_start_q, frame_start_d;

    // Next output values: all follow the counter state one tick later; the board latches at vblank start
    always_comb begin
        encode_out_d  = encode_out_q;
        area_d        = area_q;
        x_d           = x_q;
        y_d           = y_q;
        video_on_d    = video_on_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        frame_start_d = frame_start_q;
        if (tick) begin
            hsync_d       = hsync_raw;
            vsync_d       = vsync_raw;
            video_on_d    = video_on_raw;
            frame_start_d = (hcount == 10'd0) && (vcount == 10'd0);
            if ((hcount == 10'd0) && (vcount == V_VISIBLE)) begin
                encode_out_d = encode_in;
            end
            if (in_grid) begin
                area_d = AREA_ONE << cell_idx;
                x_d    = hcount - x_base;
                y_d    = vcount - y_base;
            end else begin
                area_d = '0;
                x_d    = 10'd0;
                y_d    = 10'd0;
            end
        end
    end

    // Output registers; reset parks syncs inactive so no partial pulse escapes
    always_ff @(posedge clk) begin
        if (rst) begin
            encode_out_q  <= 32'd0;
            area_q        <= '0;
            x_q           <= 10'd0;
            y_q           <= 10'd0;
            video_on_q    <= 1'b0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            encode_out_q  <= encode_out_d;
            area_q        <= area_d;
            x_q           <= x_d;
            y_q           <= y_d;
            video_on_q    <= video_on_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign encode_out  = encode_out_q;
    assign area        = area_q;
    assign x           = x_q;
    assign y           = y_q;
    assign video_on    = video_on_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_scan_area.sv
// tb/tb_vga_scan_area.sv - randomized bench for vga_scan_area against a raster-position model
module tb_vga_scan_area;

    localparam int H_ORG = 20;
    localparam int V_ORG = 40;
    localparam int CELL  = 200;
`ifdef VGA_CLKDIV_EN
    localparam int DIV = 4;
`else
    localparam int DIV = 1;
`endif
    localparam int FRAME = 800 * 525;
    localparam logic [63:0] RST_VEC = {34'd0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 10'd0, 10'd0};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] encode_in = 32'd0;
    logic [31:0] encode_out;
    logic [5:0]  area;
    logic [9:0]  x, y;
    logic        video_on, hsync, vsync, frame_start;
    logic [63:0] dut_vec;

    vga_scan_area #(.H_ORG(H_ORG), .V_ORG(V_ORG), .CELL(CELL)) dut (
        .clk         (clk),
        .rst         (rst),
        .encode_in   (encode_in),
        .encode_out  (encode_out),
        .area        (area),
        .x           (x),
        .y           (y),
        .video_on    (video_on),
        .hsync       (hsync),
        .vsync       (vsync),
        .frame_start (frame_start)
    );

    assign dut_vec = {34'd0, hsync, vsync, video_on, frame_start, area, x, y};

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Expected outputs for a raster position, straight from the timing and grid rules
    function automatic logic [63:0] pix(input int h, input int v);
        logic       hs, vs, vid, fs;
        logic [5:0] ar;
        int         xx, yy, col, row;
        hs  = !(h >= 656 && h < 752);
        vs  = !(v >= 490 && v < 492);
        vid = (h < 640) && (v < 480);
        fs  = (h == 0) && (v == 0);
        ar  = 6'd0;
        xx  = 0;
        yy  = 0;
        if (h >= H_ORG && h < H_ORG + 3 * CELL && v >= V_ORG && v < V_ORG + 2 * CELL) begin
            col = (h - H_ORG) / CELL;
            row = (v - V_ORG) / CELL;
            ar  = 6'(1 << (row * 3 + col));
            xx  = (h - H_ORG) % CELL;
            yy  = (v - V_ORG) % CELL;
        end
        return {34'd0, hs, vs, vid, fs, ar, xx[9:0], yy[9:0]};
    endfunction

    int          pos = 0;
    int          clk_cnt = 0;
    int          clk_total = 0;
    int          cur_h = 0, cur_v = 0;
    bit          ticked = 0;
    logic [63:0] exp_vec = RST_VEC;
    logic [31:0] exp_enc = 32'd0;

    // One clock: advance the model, then compare every output
    task automatic tick_clk();
        @(posedge clk);
        #1;
        clk_total++;
        if (rst) begin
            pos     = 0;
            clk_cnt = 0;
            ticked  = 0;
            exp_vec = RST_VEC;
            exp_enc = 32'd0;
        end else begin
            clk_cnt++;
            ticked = (clk_cnt % DIV == 0);
            if (ticked) begin
                cur_h   = pos % 800;
                cur_v   = pos / 800;
                exp_vec = pix(cur_h, cur_v);
                if (cur_h == 0 && cur_v == 480) exp_enc = encode_in;
                pos = (pos + 1) % FRAME;
            end
        end
        check_val("pix", dut_vec, exp_vec);
        check_val("enc", 64'(encode_out), 64'(exp_enc));
    endtask

    // Named checks at the grid corners
    task automatic spot();
        if (!ticked) return;
        if (cur_h == 20 && cur_v == 40) begin
            check_val("cell0_area", 64'(area), 64'h01);
            check_val("cell0_x", 64'(x), 64'd0);
            check_val("cell0_y", 64'(y), 64'd0);
        end
        if (cur_h == 619 && cur_v == 439) begin
            check_val("cell5_area", 64'(area), 64'h20);
            check_val("cell5_x", 64'(x), 64'd199);
            check_val("cell5_y", 64'(y), 64'd199);
        end
        if (cur_h == 620 && cur_v == 439) begin
            check_val("grid_edge_area", 64'(area), 64'd0);
        end
    endtask

    int hrun, hs_pulses, hs_wmin, hs_wmax, vrun, vs_pulses, fs_count;
    int first_fall, second_fall, ticks_done;
    logic prev_hs;

    initial begin
        rst = 1'b1;
        encode_in = $urandom;
        repeat (3) tick_clk();
        check_val("reset_vec", dut_vec, RST_VEC);
        check_val("reset_enc", 64'(encode_out), 64'd0);

        // Short runs cut by resets at random points
        for (int r = 0; r < 4; r++) begin
            int n;
            rst = 1'b0;
            n = $urandom_range(50, 3000) * DIV;
            for (int i = 0; i < n; i++) begin
                tick_clk();
                if ($urandom_range(0, 63) == 0) encode_in = $urandom;
            end
            rst = 1'b1;
            n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) tick_clk();
        end

        // Frame 1: whole-frame pulse statistics, random board changes, A5A50001 before vblank
        rst = 1'b0;
        hrun = 0; hs_pulses = 0; hs_wmin = 1000000; hs_wmax = 0;
        vrun = 0; vs_pulses = 0; fs_count = 0;
        first_fall = -1; second_fall = -1; ticks_done = 0;
        prev_hs = 1'b1;
        while (ticks_done < FRAME) begin
            tick_clk();
            spot();
            if (prev_hs && !hsync) begin
                if (first_fall < 0) first_fall = clk_total;
                else if (second_fall < 0) second_fall = clk_total;
            end
            prev_hs = hsync;
            if (ticked) begin
                ticks_done++;
                if (!hsync) hrun++;
                else if (hrun > 0) begin
                    hs_pulses++;
                    if (hrun < hs_wmin) hs_wmin = hrun;
                    if (hrun > hs_wmax) hs_wmax = hrun;
                    hrun = 0;
                end
                if (!vsync) vrun++;
                else if (vrun > 0) begin
                    vs_pulses++;
                    vrun = 0;
                end
                if (frame_start) fs_count++;
                if (cur_v >= 470) encode_in = 32'hA5A5_0001;
                else if ($urandom_range(0, 1023) == 0) encode_in = $urandom;
            end
        end
        check_val("vsync_pulses", 64'(vs_pulses), 64'd1);
        check_val("hsync_pulses", 64'(hs_pulses), 64'd525);
        check_val("hsync_wmin", 64'(hs_wmin), 64'd96);
        check_val("hsync_wmax", 64'(hs_wmax), 64'd96);
        check_val("frame_start_count", 64'(fs_count), 64'd1);
        check_val("line_clks", 64'(second_fall - first_fall), 64'(800 * DIV));

        // Frame 2: board cleared mid-frame must not show until vblank
        while (!(ticked && cur_h == 700 && cur_v == 491)) begin
            tick_clk();
            spot();
            if (ticked && cur_h == 0 && cur_v == 100) encode_in = 32'd0;
            if (ticked && cur_h == 799 && cur_v == 479)
                check_val("enc_hold", 64'(encode_out), 64'hA5A5_0001);
            if (ticked && cur_h == 0 && cur_v == 480)
                check_val("enc_load", 64'(encode_out), 64'd0);
        end

        // Reset in the middle of both sync pulses
        check_val("pre_rst_sync", 64'({hsync, vsync}), 64'd0);
        rst = 1'b1;
        tick_clk();
        check_val("rst_hsync", 64'(hsync), 64'd1);
        check_val("rst_vsync", 64'(vsync), 64'd1);
        tick_clk();
        rst = 1'b0;
        do tick_clk(); while (!ticked);
        check_val("post_rst_fs", 64'(frame_start), 64'd1);
        check_val("post_rst_hsync", 64'(hsync), 64'd1);
        check_val("post_rst_video", 64'(video_on), 64'd1);
        do tick_clk(); while (!ticked);
        check_val("post_rst_fs_off", 64'(frame_start), 64'd0);
        repeat (900 * DIV) tick_clk();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_scan_area.md
VGA_SCAN_AREA -- requirements
Module: vga_scan_area

Interface
REQ-001 Parameter H_ORG, default 20, pixel column of the grid's left edge.
REQ-002 Parameter V_ORG, default 40, pixel row of the grid's top edge.
REQ-003 Parameter CELL, default 200, side length in pixels of each square area.
REQ-004 Port clk, input, 1, the single clock; every register SHALL be clocked on its rising edge.
REQ-005 Port rst, input, 1, synchronous active-high reset.
REQ-006 Port encode_in, input, 32, live game-board encoding: shapes in [17:0], colours in [31:20].
REQ-007 Port encode_out, output, 32, frame-stable copy of encode_in.
REQ-008 Port area, output, 6, one-hot cell select; bit n = row*3+col; all zero outside the grid.
REQ-009 Port x, output, 10, pixel column relative to the current cell origin.
REQ-010 Port y, output, 10, pixel row relative to the current cell origin.
REQ-011 Port video_on, output, 1, high while the pixel is in the 640x480 visible region.
REQ-012 Port hsync, output, 1, active-low horizontal sync.
REQ-013 Port vsync, output, 1, active-low vertical sync.
REQ-014 Port frame_start, output, 1, one-pixel pulse marking the first visible pixel (0,0).

Function
REQ-015 A pixel tick SHALL advance hcount 0..799; at wrap, hcount SHALL return to 0 and vcount SHALL advance 0..524, itself wrapping to 0.
REQ-016 hsync SHALL be low for hcount 656..751; vsync SHALL be low for vcount 490..491.
REQ-017 video_on SHALL be high for hcount<640 and vcount<480.
REQ-018 col=(hcount-H_ORG)/CELL and row=(vcount-V_ORG)/CELL SHALL be computed by comparator chains, without dividers.
REQ-019 Grid membership SHALL mean H_ORG<=hcount<H_ORG+3*CELL and V_ORG<=vcount<V_ORG+2*CELL.
REQ-020 Inside the grid: area SHALL be one-hot bit row*3+col, x=hcount-H_ORG-col*CELL, y=vcount-V_ORG-row*CELL.
REQ-021 Outside the grid: area, x and y SHALL all be 0.
REQ-022 All outputs SHALL be registered and updated only on pixel ticks, with exactly one tick of latency from the counter state.
REQ-023 Sync, area, x, y and video_on SHALL remain mutually aligned.
REQ-024 encode_out SHALL load encode_in at the tick where the counter is (hcount=0, vcount=480), the start of vertical blank, and hold its value otherwise.
REQ-025 A change on encode_in mid-frame SHALL NOT affect the frame being drawn.
REQ-026 frame_start SHALL be high for exactly one pixel tick: the output tick that corresponds to counter (0,0).

Reset
REQ-027 While rst is high at a clock edge, the block SHALL set hcount=0, vcount=0, and clear the clock divider.
REQ-028 While rst is high at a clock edge, outputs SHALL take hsync=1, vsync=1, area=0, x=0, y=0, video_on=0, frame_start=0, encode_out=0.
REQ-029 A reset asserted mid-line or mid-frame SHALL restart timing from (0,0) on the first tick after release, with no partial sync pulse.

Configuration
REQ-030 When macro VGA_CLKDIV_EN is defined, a 2-bit divider SHALL generate the pixel tick every 4th clk, for a 100 MHz clk and 25 MHz pixel rate.
REQ-031 When VGA_CLKDIV_EN is undefined, every clk cycle SHALL be a pixel tick, clk being the 25 MHz pixel clock.

Structure
REQ-032 Shared package vga_pkg SHALL hold the horizontal and vertical visible, front-porch, sync, back-porch and total constants, plus the area count (6).
REQ-033 Sub-module vga_timing SHALL own the counters, the divider, and raw sync and video_on generation.
REQ-034 vga_scan_area SHALL add the cell decode, the encode latch and output registration.

Verification
REQ-035 Release rst, then run 800*525 ticks -> exactly one vsync pulse, 525 hsync pulses each 96 ticks wide, and frame_start exactly once.
REQ-036 Counter at (hcount=20, vcount=40) -> next tick area=6'b000001, x=0, y=0.
REQ-037 Counter at (hcount=619, vcount=439) -> next tick area=6'b100000, x=199, y=199; counter at (620, 439) -> next tick area=0.
REQ-038 encode_in=32'hA5A5_0001 held, changed to 32'h0 at vcount=100 -> encode_out=A5A50001 until vcount=480, then 0.
REQ-039 Assert rst at (hcount=700, vcount=491), mid-sync -> hsync=1 and vsync=1 immediately, and the first post-reset tick corresponds to (0,0).
REQ-040 With VGA_CLKDIV_EN defined -> outputs change only every 4th clk, and a line lasts 3200 clk.
